// File: rtl/uart_tx_frame.sv
// UART transmit frame builder: latches one word per request and serializes
// start, data (LSB first), optional parity and 1 or 2 stop bits on baud_tick.
module uart_tx_frame #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  baud_tick,
   input  logic                  send,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic [1:0]            parity_type,
   input  logic                  stop_bits,
   output logic                  tx,
   output logic                  busy,
   output logic                  done
);

   localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t                state, state_nxt;
   logic [DATA_WIDTH-1:0] data_reg, data_nxt;
   logic [1:0]            ptype_reg, ptype_nxt;
   logic                  stop2_reg, stop2_nxt;
   logic [CNT_W-1:0]      bit_cnt, bit_cnt_nxt;
   logic                  stop_cnt, stop_cnt_nxt;
   logic                  tx_nxt, busy_nxt, done_nxt;
   logic [CNT_W-1:0]      bit_inc;

   // 01 selects odd parity, 10 even; the other encodings carry no parity bit.
   function automatic logic has_parity(input logic [1:0] ptype);
      return (ptype == 2'b01) || (ptype == 2'b10);
   endfunction

   function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] d,
                                       input logic [1:0] ptype);
      return (ptype == 2'b01) ? ~^d : ^d;
   endfunction

   assign bit_inc = bit_cnt + 1'b1;

   always_comb begin
      state_nxt    = state;
      data_nxt     = data_reg;
      ptype_nxt    = ptype_reg;
      stop2_nxt    = stop2_reg;
      bit_cnt_nxt  = bit_cnt;
      stop_cnt_nxt = stop_cnt;
      tx_nxt       = tx;
      busy_nxt     = busy;
      done_nxt     = 1'b0;

      case (state)
         S_IDLE: begin
            tx_nxt   = 1'b1;
            busy_nxt = 1'b0;
            // A tick arriving with the request is ignored; WAIT needs a later one.
            if (send && !busy) begin
               data_nxt     = data_in;
               ptype_nxt    = parity_type;
               stop2_nxt    = stop_bits;
               bit_cnt_nxt  = '0;
               stop_cnt_nxt = 1'b0;
               busy_nxt     = 1'b1;
               state_nxt    = S_WAIT;
            end
         end
         S_WAIT: begin
            if (baud_tick) begin
               tx_nxt    = 1'b0;
               state_nxt = S_START;
            end
         end
         S_START: begin
            if (baud_tick) begin
               tx_nxt      = data_reg[0];
               bit_cnt_nxt = '0;
               state_nxt   = S_DATA;
            end
         end
         S_DATA: begin
            if (baud_tick) begin
               if (bit_cnt == LAST_BIT) begin
                  stop_cnt_nxt = 1'b0;
                  if (has_parity(ptype_reg)) begin
                     tx_nxt    = parity_bit(data_reg, ptype_reg);
                     state_nxt = S_PARITY;
                  end else begin
                     tx_nxt    = 1'b1;
                     state_nxt = S_STOP;
                  end
               end else begin
                  bit_cnt_nxt = bit_inc;
                  tx_nxt      = data_reg[bit_inc];
               end
            end
         end
         S_PARITY: begin
            if (baud_tick) begin
               tx_nxt       = 1'b1;
               stop_cnt_nxt = 1'b0;
               state_nxt    = S_STOP;
            end
         end
         S_STOP: begin
            if (baud_tick) begin
               tx_nxt = 1'b1;
               if (stop2_reg && !stop_cnt) begin
                  stop_cnt_nxt = 1'b1;
               end else begin
                  done_nxt  = 1'b1;
                  busy_nxt  = 1'b0;
                  state_nxt = S_IDLE;
               end
            end
         end
         default: begin
            tx_nxt    = 1'b1;
            busy_nxt  = 1'b0;
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= S_IDLE;
         data_reg  <= '0;
         ptype_reg <= '0;
         stop2_reg <= 1'b0;
         bit_cnt   <= '0;
         stop_cnt  <= 1'b0;
         tx        <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_nxt;
         data_reg  <= data_nxt;
         ptype_reg <= ptype_nxt;
         stop2_reg <= stop2_nxt;
         bit_cnt   <= bit_cnt_nxt;
         stop_cnt  <= stop_cnt_nxt;
         tx        <= tx_nxt;
         busy      <= busy_nxt;
         done      <= done_nxt;
      end
   end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: expected frames are queued at send time
// and checked bit by bit by a line monitor as they appear on tx.
module tb_uart_tx_frame;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       baud_tick = 1'b0;
   logic       send = 1'b0;
   logic [7:0] data_in = '0;
   logic [1:0] parity_type = '0;
   logic       stop_bits = 1'b0;
   logic       tx, busy, done;

   typedef struct {
      logic [11:0] bits;
      int          len;
   } frame_t;

   frame_t exp_q[$];
   int     start_cyc[$];
   int     checks = 0;
   int     errors = 0;
   int     cyc = 0;
   int     done_cnt = 0;
   bit     mon_active = 1'b0;

   uart_tx_frame #(.DATA_WIDTH(8)) dut (
      .clk(clk), .reset_n(reset_n), .baud_tick(baud_tick), .send(send),
      .data_in(data_in), .parity_type(parity_type), .stop_bits(stop_bits),
      .tx(tx), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (reset_n && done === 1'b1) done_cnt <= done_cnt + 1;

   // Free-running bit clock: one-cycle tick every 16 clocks.
   initial begin
      forever begin
         repeat (15) @(negedge clk);
         baud_tick = 1'b1;
         @(negedge clk);
         baud_tick = 1'b0;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic frame_t model(input logic [7:0] d, input logic [1:0] pt, input logic sb);
      frame_t f;
      int     ones;
      f.bits = '0;
      ones   = 0;
      f.bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) begin
         f.bits[1 + i] = d[i];
         if (d[i]) ones++;
      end
      f.len = 9;
      if (pt == 2'b01) begin
         f.bits[f.len] = (ones % 2 == 0);
         f.len++;
      end else if (pt == 2'b10) begin
         f.bits[f.len] = (ones % 2 == 1);
         f.len++;
      end
      f.bits[f.len] = 1'b1;
      f.len++;
      if (sb) begin
         f.bits[f.len] = 1'b1;
         f.len++;
      end
      return f;
   endfunction

   // Line monitor: each bit must hold for its full 16-clock interval.
   frame_t mf;
   bit     mab;
   int     fidx = 0;
   logic   prev_tx = 1'b1;
   initial begin
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            prev_tx = 1'b1;
         end else if (prev_tx === 1'b1 && tx === 1'b0) begin
            start_cyc.push_back(cyc);
            check($sformatf("frame%0d_expected", fidx), 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
               mf = exp_q.pop_front();
               mab = 1'b0;
               mon_active = 1'b1;
               for (int off = 1; off < mf.len * 16 && !mab; off++) begin
                  @(negedge clk);
                  if (!reset_n) mab = 1'b1;
                  else if (off % 16 == 1 || off % 16 == 15)
                     check($sformatf("frame%0d_bit%0d_off%0d", fidx, off / 16, off % 16),
                           32'(tx), 32'(mf.bits[off / 16]));
               end
               if (!mab) begin
                  @(negedge clk);
                  if (reset_n) check($sformatf("frame%0d_done_at_end", fidx), 32'(done), 1);
               end
               mon_active = 1'b0;
            end
            fidx++;
            prev_tx = 1'b1;
         end else begin
            prev_tx = tx;
         end
      end
   end

   task automatic send_frame(input logic [7:0] d, input logic [1:0] pt, input logic sb);
      @(negedge clk);
      data_in = d; parity_type = pt; stop_bits = sb; send = 1'b1;
      exp_q.push_back(model(d, pt, sb));
      @(negedge clk);
      send = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (done !== 1'b1 && n < 400) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_done"}, 32'(done), 1);
      check({tag, "_busy_in_done"}, 32'(busy), 0);
      @(negedge clk);
      check({tag, "_done_one_clk"}, 32'(done), 0);
   endtask

   initial begin
      int d0;
      int n;
      repeat (3) @(negedge clk);
      check("reset_tx", 32'(tx), 1);
      check("reset_busy", 32'(busy), 0);
      check("reset_done", 32'(done), 0);
      reset_n = 1'b1;
      repeat (5) @(negedge clk);

      // 0x55 even, one stop
      d0 = done_cnt;
      send_frame(8'h55, 2'b10, 1'b0);
      check("t1_busy", 32'(busy), 1);
      wait_done("t1");
      repeat (20) @(negedge clk);
      check("t1_done_count", done_cnt - d0, 1);

      // 0xA5 odd, one stop
      send_frame(8'hA5, 2'b01, 1'b0);
      wait_done("t2");
      repeat (10) @(negedge clk);

      // 0x00 no parity (11), two stops
      send_frame(8'h00, 2'b11, 1'b1);
      wait_done("t3");
      repeat (10) @(negedge clk);

      // send pulsed mid-frame is ignored
      d0 = done_cnt;
      send_frame(8'h0F, 2'b10, 1'b0);
      repeat (70) @(negedge clk);
      data_in = 8'hFF; send = 1'b1;
      @(negedge clk);
      send = 1'b0;
      wait_done("t4");
      repeat (40) @(negedge clk);
      check("t4_done_count", done_cnt - d0, 1);
      check("t4_idle", 32'(busy), 0);

      // asynchronous reset in data bit 3
      send_frame(8'hC3, 2'b01, 1'b0);
      n = 0;
      while (tx !== 1'b0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("t5_start_seen", 32'(tx), 0);
      repeat (72) @(negedge clk);
      d0 = done_cnt;
      #2 reset_n = 1'b0;
      #1;
      check("t5_async_tx", 32'(tx), 1);
      check("t5_async_busy", 32'(busy), 0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (40) @(negedge clk);
      check("t5_no_done", done_cnt - d0, 0);
      send_frame(8'h3C, 2'b10, 1'b0);
      wait_done("t5b");
      repeat (10) @(negedge clk);

      // send held high: two back-to-back frames
      @(negedge clk);
      data_in = 8'h12; parity_type = 2'b00; stop_bits = 1'b0; send = 1'b1;
      exp_q.push_back(model(8'h12, 2'b00, 1'b0));
      exp_q.push_back(model(8'h34, 2'b00, 1'b0));
      @(negedge clk);
      data_in = 8'h34;
      wait_done("t6a");
      check("t6_second_accepted", 32'(busy), 1);
      send = 1'b0;
      wait_done("t6b");
      repeat (10) @(negedge clk);
      check("t6_start_spacing",
            (start_cyc.size() >= 2) ? start_cyc[start_cyc.size()-1] - start_cyc[start_cyc.size()-2] : -1,
            176);

      n = 0;
      while (mon_active && n < 400) begin
         @(negedge clk);
         n++;
      end
      check("queue_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
